// File: rtl/rom_rr_arbiter.sv
// rom_rr_arbiter
//   Shares one synchronous single-port ROM between NREQ requesters using
//   round-robin arbitration. One read is in flight at a time, sequenced by a
//   three-state FSM (IDLE -> READ -> CAPT -> IDLE). All outputs are registered.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous, active-high reset
//   req        level request per requester
//   req_addr   packed addresses, requester i uses [i*AW +: AW]
//   gnt        one-hot, one-cycle grant pulse
//   rsp_valid  one-hot, one-cycle response pulse
//   rsp_data   ROM word of the latest response (held until the next one)
//   rom_en     ROM enable
//   rom_addr   ROM address
//   rom_data   ROM data_out (valid the cycle after the ROM samples en/addr)
//   dbg_state  current FSM state, for observation only
//
// Handshake: a requester raises req[i] with a stable req_addr slice and keeps
// it high until it sees rsp_valid[i]. The arbiter answers with a gnt[i] pulse
// (edge E0), then an rsp_valid[i] pulse with rsp_data (edge E2). Once granted,
// the transaction always completes, even if req[i] drops; only reset aborts it.
module rom_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int AW   = 3,
  parameter int DW   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*AW-1:0] req_addr,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [DW-1:0]      rsp_data,
  output logic               rom_en,
  output logic [AW-1:0]      rom_addr,
  input  logic [DW-1:0]      rom_data,
  output logic [1:0]         dbg_state
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_READ = 2'd1;
  localparam logic [1:0] S_CAPT = 2'd2;

  localparam logic [NREQ-1:0] ONE = NREQ'(1);

  logic [1:0]      state;
  logic [IW-1:0]   ptr;   // last granted requester; search starts at ptr+1
  logic [IW-1:0]   cur;   // requester owning the transaction in flight
  logic [NREQ-1:0] eligible;
  logic            found;
  logic [IW-1:0]   pick;
  int              cand;

  assign dbg_state = state;

  // A requester answered in the previous cycle still has req high on this
  // edge; masking with rsp_valid keeps it from being re-granted immediately.
  always_comb begin
    eligible = req & ~rsp_valid;
    found    = 1'b0;
    pick     = '0;
    cand     = 0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = int'(ptr) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!found && eligible[IW'(cand)]) begin
        found = 1'b1;
        pick  = IW'(cand);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      gnt       <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      rom_en    <= 1'b0;
      rom_addr  <= '0;
      ptr       <= IW'(NREQ - 1);
      cur       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          rsp_valid <= '0;
          if (found) begin
            gnt      <= ONE << pick;
            rom_en   <= 1'b1;
            rom_addr <= req_addr[pick*AW +: AW];
            cur      <= pick;
            ptr      <= pick;
            state    <= S_READ;
          end
        end
        S_READ: begin
          // ROM samples en/addr on this edge; rom_addr keeps its value.
          gnt    <= '0;
          rom_en <= 1'b0;
          state  <= S_CAPT;
        end
        S_CAPT: begin
          rsp_data  <= rom_data;
          rsp_valid <= ONE << cur;
          state     <= S_IDLE;
        end
        default: begin
          gnt       <= '0;
          rsp_valid <= '0;
          rom_en    <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rom_rr_arbiter.sv
module tb_rom_rr_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 3;
  localparam int DW   = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    rsp_valid;
  logic [DW-1:0]      rsp_data;
  logic               rom_en;
  logic [AW-1:0]      rom_addr;
  logic [DW-1:0]      rom_data;
  logic [1:0]         dbg_state;

  rom_rr_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_addr  (req_addr),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rom_en    (rom_en),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .dbg_state (dbg_state)
  );

  // ROM model: word = A0 | addr, registered output.
  logic [DW-1:0] rom_q = '0;
  always @(posedge clk) if (rom_en) rom_q <= 8'hA0 | 8'(rom_addr);
  assign rom_data = rom_q;

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic set_addr(input int i, input logic [AW-1:0] v);
    req_addr[i*AW +: AW] = v;
  endtask

  // ---------------- scoreboard / monitor ----------------
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Inputs as the DUT saw them at the last rising edge.
  logic [NREQ*AW-1:0] addr_shadow;
  always @(posedge clk) addr_shadow <= req_addr;

  logic [DW-1:0] exp_q[$];
  int            who_q[$];
  int            grant_log[$];
  int            grant_cyc[$];
  logic [DW-1:0] rsp_log[$];
  int            mon_idx;
  logic [DW-1:0] mon_e;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      who_q.delete();
    end else begin
      chk("gnt_onehot0", 32'($onehot0(gnt)), 1);
      chk("rsp_onehot0", 32'($onehot0(rsp_valid)), 1);
      chk("rom_en_with_gnt", 32'(rom_en), 32'(|gnt));
      if (|gnt) begin
        mon_idx = 0;
        for (int i = 0; i < NREQ; i++) if (gnt[i]) mon_idx = i;
        grant_log.push_back(mon_idx);
        grant_cyc.push_back(cyc);
        exp_q.push_back(8'hA0 | 8'(addr_shadow[mon_idx*AW +: AW]));
        who_q.push_back(mon_idx);
      end
      if (|rsp_valid) begin
        rsp_log.push_back(rsp_data);
        if (exp_q.size() == 0) begin
          chk("rsp_orphan", 32'(rsp_valid), 0);
        end else begin
          mon_e   = exp_q.pop_front();
          mon_idx = who_q.pop_front();
          chk("sb_data", 32'(rsp_data), 32'(mon_e));
          chk("sb_who", 32'(rsp_valid), 32'(1 << mon_idx));
        end
      end
    end
  end

  task automatic clear_logs();
    grant_log.delete();
    grant_cyc.delete();
    rsp_log.delete();
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    #2 rst = 1'b1;
    repeat (n) @(negedge clk);
    #2 rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  int tmr[NREQ];
  int g0;
  int pos2;

  initial begin
    rst = 1'b1;
    req = '0;
    req_addr = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rom_en", 32'(rom_en), 0);
    chk("rst_rom_addr", 32'(rom_addr), 0);
    chk("rst_rsp_data", 32'(rsp_data), 0);
    chk("rst_state", 32'(dbg_state), 0);
    #2 rst = 1'b0;

    // Single request, latency
    @(negedge clk);
    set_addr(0, 3'd3);
    req = 4'b0001;
    @(negedge clk);
    chk("t1_gnt", 32'(gnt), 4'b0001);
    chk("t1_rom_en", 32'(rom_en), 1);
    chk("t1_rom_addr", 32'(rom_addr), 3);
    @(negedge clk);
    chk("t1_gnt_off", 32'(gnt), 0);
    chk("t1_rom_en_off", 32'(rom_en), 0);
    chk("t1_rom_addr_hold", 32'(rom_addr), 3);
    chk("t1_rsp_early", 32'(rsp_valid), 0);
    @(negedge clk);
    chk("t1_rsp_valid", 32'(rsp_valid), 4'b0001);
    chk("t1_rsp_data", 32'(rsp_data), 8'hA3);
    req = '0;
    @(negedge clk);
    chk("t1_rsp_off", 32'(rsp_valid), 0);
    chk("t1_no_regrant", 32'(gnt), 0);
    chk("t1_data_hold", 32'(rsp_data), 8'hA3);

    // All-request fairness from a fresh pointer
    do_reset(2);
    clear_logs();
    for (int i = 0; i < NREQ; i++) begin
      set_addr(i, AW'(i));
      tmr[i] = 0;
    end
    req = 4'b1111;
    for (int c = 0; c < 80 && grant_log.size() < 8; c++) begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) begin
        if (rsp_valid[i]) begin
          req[i] = 1'b0;
          tmr[i] = 2;
        end else if (tmr[i] > 0) begin
          tmr[i]--;
          if (tmr[i] == 0) req[i] = 1'b1;
        end
      end
    end
    req = '0;
    repeat (6) @(negedge clk);
    chk("fair_count", 32'(grant_log.size() >= 8), 1);
    for (int k = 0; k < 8 && k < grant_log.size(); k++)
      chk("fair_order", 32'(grant_log[k]), 32'(k % 4));
    for (int k = 0; k < 7 && k + 1 < grant_cyc.size(); k++)
      chk("fair_spacing", 32'(grant_cyc[k+1] - grant_cyc[k]), 3);
    for (int k = 0; k < 8 && k < rsp_log.size(); k++)
      chk("fair_data", 32'(rsp_log[k]), 32'h A0 + 32'(k % 4));

    // Anti-starvation: req0 always high, req2 joins
    clear_logs();
    set_addr(0, 3'd5);
    set_addr(2, 3'd6);
    req = 4'b0001;
    repeat (10) @(negedge clk);
    for (int c = 0; c < 10 && gnt != 0; c++) @(negedge clk);
    chk("lone_grants", 32'(grant_log.size() >= 2), 1);
    if (grant_cyc.size() >= 2)
      chk("lone_gap", 32'(grant_cyc[1] - grant_cyc[0]), 4);
    g0 = grant_log.size();
    req[2] = 1'b1;
    for (int c = 0; c < 40 && grant_log.size() < g0 + 2; c++) begin
      @(negedge clk);
      if (rsp_valid[2]) req[2] = 1'b0;
    end
    req = '0;
    repeat (6) @(negedge clk);
    pos2 = -1;
    for (int k = g0; k < grant_log.size() && k < g0 + 2; k++)
      if (pos2 < 0 && grant_log[k] == 2) pos2 = k - g0;
    chk("starve_within2", 32'(pos2 >= 0 && pos2 <= 1), 1);
    if (grant_log.size() > g0)
      chk("starve_no_double0", 32'(grant_log[g0] != 0), 1);

    // Address wrap and rom_addr stability during READ
    @(negedge clk);
    set_addr(1, 3'd7);
    req = 4'b0010;
    @(negedge clk);
    chk("wrap_gnt7", 32'(gnt), 4'b0010);
    chk("wrap_addr7", 32'(rom_addr), 7);
    set_addr(1, 3'd2);
    @(negedge clk);
    chk("wrap_addr_hold", 32'(rom_addr), 7);
    @(negedge clk);
    chk("wrap_rsp7", 32'(rsp_valid), 4'b0010);
    chk("wrap_data7", 32'(rsp_data), 8'hA7);
    req = '0;
    @(negedge clk);
    set_addr(1, 3'd0);
    req = 4'b0010;
    @(negedge clk);
    chk("wrap_gnt0", 32'(gnt), 4'b0010);
    chk("wrap_addr0", 32'(rom_addr), 0);
    @(negedge clk);
    @(negedge clk);
    chk("wrap_rsp0", 32'(rsp_valid), 4'b0010);
    chk("wrap_data0", 32'(rsp_data), 8'hA0);
    req = '0;
    @(negedge clk);

    // Reset in the middle of a read
    set_addr(3, 3'd4);
    req = 4'b1000;
    @(negedge clk);
    chk("mid_gnt3", 32'(gnt), 4'b1000);
    #2 rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_gnt", 32'(gnt), 0);
    chk("mid_rst_en", 32'(rom_en), 0);
    chk("mid_rst_state", 32'(dbg_state), 0);
    req = '0;
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("mid_no_rsp", 32'(rsp_valid), 0);
    end
    req = 4'b1000;
    @(negedge clk);
    chk("mid_regnt3", 32'(gnt), 4'b1000);
    chk("mid_addr", 32'(rom_addr), 4);
    @(negedge clk);
    @(negedge clk);
    chk("mid_rsp3", 32'(rsp_valid), 4'b1000);
    chk("mid_data", 32'(rsp_data), 8'hA4);
    req = '0;
    @(negedge clk);

    // Early drop after grant
    set_addr(2, 3'd1);
    req = 4'b0100;
    @(negedge clk);
    chk("drop_gnt2", 32'(gnt), 4'b0100);
    req = '0;
    @(negedge clk);
    chk("drop_rsp_early", 32'(rsp_valid), 0);
    @(negedge clk);
    chk("drop_rsp2", 32'(rsp_valid), 4'b0100);
    chk("drop_data", 32'(rsp_data), 8'hA1);
    g0 = grant_log.size();
    repeat (6) @(negedge clk);
    chk("drop_no_regrant", 32'(grant_log.size()), 32'(g0));

    chk("sb_empty", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
